keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 active-low matrix keypad, synchronises and debounces all 16 keys, and emits single-cycle
//  one-hot press pulses on key_pulse[15:0]. Sits directly upstream of the mode controller, which decodes
//  exact one-hot values, so at most one key_pulse bit is ever high in a given cycle.
// PARAMETERS
//  SCAN_DIV        5000  clk cycles per row slot; must be >=4. A full scan takes 4*SCAN_DIV cycles.
//  DEBOUNCE_SCANS  4     consecutive full scans a raw key value must differ from key_state before key_state updates; >=1
// PORTS
//  clk        input   1   system clock
//  rst        input   1   asynchronous, active-high reset
//  col_in     input   4   keypad columns, active-low, externally pulled up, asynchronous to clk
//  row_out    output  4   keypad rows, active-low, exactly one row low at any time
//  key_state  output  16  debounced level per key, 1 = pressed; index = row*4 + col
//  key_pulse  output  16  one-cycle one-hot press event; 16'h0000 when idle
// BEHAVIOUR
//  Reset (async, rst=1): row_out=4'b1110, key_state=0, key_pulse=0.
//   Also cleared: row index, slot divider, column synchronisers (reset to 4'b1111), raw vector, debounce counters, pending.
//  Sync: col_in passes through a 2-FF synchroniser before any use.
//  Row sequencing:
//   - Divider counts 0..SCAN_DIV-1; row index 0..3 drives row_out = ~(1<<row).
//   - The sample point is divider==SCAN_DIV-1. At that point, raw[row*4+c] <= ~col_sync[c] for c=0..3.
//   - In the same cycle the row index advances and wraps 3->0.
//   - scan_done pulses one cycle on the sample point of row 3.
//  Debounce (evaluated only on scan_done, per key k, counter width clog2(DEBOUNCE_SCANS+1)):
//   - raw[k]==key_state[k]: cnt[k] <= 0.
//   - else, if cnt[k]+1 == DEBOUNCE_SCANS: key_state[k] <= raw[k], cnt[k] <= 0.
//   - else: cnt[k] <= cnt[k]+1.
//   - Any mismatch-free scan resets the count; there is no partial credit.
//  Press detection:
//   - On the cycle key_state[k] rises, pending[k] is set. Falling edges (release) set nothing.
//  Pulse serialiser:
//   - Each cycle with pending!=0: key_pulse <= lowest set bit of pending, and that bit is cleared.
//   - Otherwise key_pulse <= 0.
//   - Newly set pending bits are OR-ed in the same cycle without losing a bit being served.
//   - Latency: key_pulse for key k is high in the cycle after key_state[k] rises, if no lower-index bit is pending.
//     Otherwise it is delayed one cycle per lower pending bit (max 15).
//   - A pending bit is served even if the key releases before service.
//  Boundaries:
//   - Multiple keys pressed: each key debounced independently.
//   - Ghosting is not suppressed.
//   - A key held continuously produces exactly one pulse.
//   - Reset asserted mid-scan or mid-debounce: all state returns to reset values immediately. No pulse is emitted for pending keys.
//   - After release, rst deasserts synchronously inside the block (2-FF release); scanning restarts at row 0, divider 0.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=3; one full scan = 16 cycles)
//  1. Idle, col_in=4'hF -> row_out cycles 1110,1101,1011,0111 for 4 clk each and repeats; key_pulse stays 0; key_state stays 0.
//  2. Press key 5: col_in[1]=0 whenever row_out==4'b1101, held.
//     -> key_state[5]=1 after the 3rd scan_done; key_pulse==16'h0020 for exactly 1 cycle; no further pulse while held.
//  3. Bounce key 5: press for 2 scans, release for 1, press for 2 scans, then release -> no key_pulse; key_state stays 0.
//  4. Keys 0 and 2 pressed in the same scan.
//     -> key_pulse==16'h0001 then 16'h0004 on consecutive cycles; never both bits in one cycle.
//  5. Release key 5 after test 2 -> key_state[5] clears after 3 scans; key_pulse stays 0.
//  6. rst pulse 1 scan into a debounce of key 9.
//     -> all outputs at reset values during rst. Key held afterward: pulse 16'h0200 only after 3 scans counted from reset release.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row strobing, 2-FF column sync, per-key scan debounce
// and a serialiser that turns debounced press edges into one-hot single-cycle pulses.
module keypad_scanner #(
   parameter int SCAN_DIV       = 5000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  col_in,
   output logic [3:0]  row_out,
   output logic [15:0] key_state,
   output logic [15:0] key_pulse
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

   logic [1:0]             rst_sync_reg;
   logic                   rst_int;
   logic [3:0]             col_meta_reg;
   logic [3:0]             col_sync_reg;
   logic [DIV_W-1:0]       div_reg;
   logic [1:0]             row_reg;
   logic [15:0]            raw_reg;
   logic [15:0]            raw_next;
   logic [15:0][CNT_W-1:0] cnt_reg;
   logic [15:0][CNT_W-1:0] cnt_next;
   logic [15:0]            key_state_reg;
   logic [15:0]            key_state_next;
   logic [15:0]            pending_reg;
   logic [15:0]            pending_next;
   logic [15:0]            key_pulse_reg;
   logic [15:0]            served;
   logic [15:0]            rise;
   logic                   sample;
   logic                   scan_done;

   // Reset asserts immediately but is released only after two clean clock edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_sync_reg <= 2'b11;
      end else begin
         rst_sync_reg <= {rst_sync_reg[0], 1'b0};
      end
   end

   assign rst_int   = rst_sync_reg[1];
   assign sample    = (div_reg == DIV_LAST);
   assign scan_done = sample && (row_reg == 2'd3);
   assign row_out   = ~(4'b0001 << row_reg);

   // Debounce sees the freshly sampled row 3 through raw_next, so every scan is complete.
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_key
         logic mismatch;
         logic hit;

         assign raw_next[gi] = (sample && (row_reg == 2'(gi / 4))) ? ~col_sync_reg[gi % 4]
                                                                    : raw_reg[gi];
         assign mismatch = (raw_next[gi] != key_state_reg[gi]);
         assign hit      = mismatch && (cnt_reg[gi] == CNT_LAST);

         assign cnt_next[gi] = !scan_done             ? cnt_reg[gi] :
                               (!mismatch || hit)     ? '0 :
                                                        cnt_reg[gi] + CNT_W'(1);
         assign key_state_next[gi] = (scan_done && hit) ? raw_next[gi] : key_state_reg[gi];
      end
   endgenerate

   assign rise         = key_state_next & ~key_state_reg;
   assign served       = pending_reg & (~pending_reg + 16'd1);
   assign pending_next = (pending_reg & ~served) | rise;

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         col_meta_reg  <= 4'b1111;
         col_sync_reg  <= 4'b1111;
         div_reg       <= '0;
         row_reg       <= 2'd0;
         raw_reg       <= '0;
         cnt_reg       <= '0;
         key_state_reg <= '0;
         pending_reg   <= '0;
         key_pulse_reg <= '0;
      end else begin
         col_meta_reg  <= col_in;
         col_sync_reg  <= col_meta_reg;
         div_reg       <= sample ? '0 : div_reg + DIV_W'(1);
         if (sample) begin
            row_reg <= row_reg + 2'd1;
         end
         raw_reg       <= raw_next;
         cnt_reg       <= cnt_next;
         key_state_reg <= key_state_next;
         pending_reg   <= pending_next;
         key_pulse_reg <= served;
      end
   end

   assign key_state = key_state_reg;
   assign key_pulse = key_pulse_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 and a behavioural keypad matrix.
module tb_keypad_scanner;

   logic        clk;
   logic        rst;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic [15:0] key_state;
   logic [15:0] key_pulse;
   logic [15:0] pressed;

   int pass_cnt;
   int total_cnt;
   int e;

   keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .col_in    (col_in),
      .row_out   (row_out),
      .key_state (key_state),
      .key_pulse (key_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      col_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!row_out[r]) begin
            for (int c = 0; c < 4; c++) begin
               if (pressed[r*4+c]) col_in[c] = 1'b0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      e++;
   endtask

   // Edge e counts posedges after rst falls on a negedge; edge 1 is the first one.
   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      e = 0;
   endtask

   task automatic test_reset();
      pressed = 16'h0000;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if (row_out !== 4'b1110) $display("FAIL reset_row_out got=%b exp=%b", row_out, 4'b1110);
      else pass_cnt++;
      total_cnt++;
      if (key_state !== 16'h0000) $display("FAIL reset_key_state got=%h exp=%h", key_state, 16'h0000);
      else pass_cnt++;
      total_cnt++;
      if (key_pulse !== 16'h0000) $display("FAIL reset_key_pulse got=%h exp=%h", key_pulse, 16'h0000);
      else pass_cnt++;
      $display("test_reset: outputs at reset values while rst is high");
   endtask

   task automatic test_idle();
      logic [3:0] exp_row;
      int r;
      pressed = 16'h0000;
      do_reset();
      while (e < 70) begin
         step();
         r = (e >= 2) ? ((e - 2) / 4) % 4 : 0;
         exp_row = 4'b1111 ^ (4'b0001 << r);
         total_cnt++;
         if (row_out !== exp_row || key_pulse !== 16'h0000 || key_state !== 16'h0000)
            $display("FAIL idle_edge%0d row_out=%b exp=%b pulse=%h state=%h exp=0000/0000",
                     e, row_out, exp_row, key_pulse, key_state);
         else pass_cnt++;
      end
      $display("test_idle: 70 cycles of row sequencing with no keys");
   endtask

   task automatic test_press();
      int pulses;
      int pulse_edge;
      pulses = 0;
      pulse_edge = -1;
      pressed = 16'h0020;
      do_reset();
      while (e < 100) begin
         step();
         if (key_pulse !== 16'h0000) begin
            pulses++;
            pulse_edge = e;
            total_cnt++;
            if (key_pulse !== 16'h0020) $display("FAIL press_pulse_value got=%h exp=%h", key_pulse, 16'h0020);
            else pass_cnt++;
         end
         if (e == 49) begin
            total_cnt++;
            if (key_state !== 16'h0000) $display("FAIL press_state_before got=%h exp=%h", key_state, 16'h0000);
            else pass_cnt++;
         end
         if (e == 50) begin
            total_cnt++;
            if (key_state !== 16'h0020) $display("FAIL press_state_after got=%h exp=%h", key_state, 16'h0020);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (pulses != 1) $display("FAIL press_pulse_count got=%0d exp=1", pulses);
      else pass_cnt++;
      total_cnt++;
      if (pulse_edge != 51) $display("FAIL press_pulse_edge got=%0d exp=51", pulse_edge);
      else pass_cnt++;
      $display("test_press: key 5 held, pulses=%0d at edge %0d", pulses, pulse_edge);
   endtask

   // Continues from test_press without a reset: released just after edge 100.
   task automatic test_release();
      int pulses;
      pulses = 0;
      pressed = 16'h0000;
      while (e < 160) begin
         step();
         if (key_pulse !== 16'h0000) pulses++;
         if (e == 145) begin
            total_cnt++;
            if (key_state !== 16'h0020) $display("FAIL release_state_before got=%h exp=%h", key_state, 16'h0020);
            else pass_cnt++;
         end
         if (e == 146) begin
            total_cnt++;
            if (key_state !== 16'h0000) $display("FAIL release_state_after got=%h exp=%h", key_state, 16'h0000);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (pulses != 0) $display("FAIL release_pulse_count got=%0d exp=0", pulses);
      else pass_cnt++;
      $display("test_release: key 5 released, pulses=%0d", pulses);
   endtask

   task automatic test_bounce();
      int pulses;
      int state_hits;
      pulses = 0;
      state_hits = 0;
      pressed = 16'h0020;
      do_reset();
      while (e < 130) begin
         step();
         if (e == 34) pressed = 16'h0000;
         if (e == 50) pressed = 16'h0020;
         if (e == 82) pressed = 16'h0000;
         if (key_pulse !== 16'h0000) pulses++;
         if (key_state !== 16'h0000) state_hits++;
      end
      total_cnt++;
      if (pulses != 0) $display("FAIL bounce_pulse_count got=%0d exp=0", pulses);
      else pass_cnt++;
      total_cnt++;
      if (state_hits != 0) $display("FAIL bounce_state_cycles got=%0d exp=0", state_hits);
      else pass_cnt++;
      $display("test_bounce: 2 on / 1 off / 2 on / off, pulses=%0d", pulses);
   endtask

   task automatic test_two_keys();
      int multi;
      multi = 0;
      pressed = 16'h0005;
      do_reset();
      while (e < 70) begin
         step();
         if ($countones(key_pulse) > 1) multi++;
         if (e == 50) begin
            total_cnt++;
            if (key_state !== 16'h0005) $display("FAIL two_state got=%h exp=%h", key_state, 16'h0005);
            else pass_cnt++;
         end
         if (e == 51) begin
            total_cnt++;
            if (key_pulse !== 16'h0001) $display("FAIL two_first_pulse got=%h exp=%h", key_pulse, 16'h0001);
            else pass_cnt++;
         end
         if (e == 52) begin
            total_cnt++;
            if (key_pulse !== 16'h0004) $display("FAIL two_second_pulse got=%h exp=%h", key_pulse, 16'h0004);
            else pass_cnt++;
         end
         if (e == 53) begin
            total_cnt++;
            if (key_pulse !== 16'h0000) $display("FAIL two_idle_after got=%h exp=%h", key_pulse, 16'h0000);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (multi != 0) $display("FAIL two_onehot_cycles got=%0d exp=0", multi);
      else pass_cnt++;
      $display("test_two_keys: keys 0 and 2 served on consecutive cycles");
   endtask

   task automatic test_reset_mid();
      int pulses;
      int pulse_edge;
      pulses = 0;
      pulse_edge = -1;
      pressed = 16'h0200;
      do_reset();
      while (e < 24) step();
      total_cnt++;
      if (row_out !== 4'b1101) $display("FAIL mid_row_before got=%b exp=%b", row_out, 4'b1101);
      else pass_cnt++;
      rst = 1'b1;
      #1;
      total_cnt++;
      if (row_out !== 4'b1110 || key_state !== 16'h0000 || key_pulse !== 16'h0000)
         $display("FAIL mid_async_reset row_out=%b state=%h pulse=%h exp=1110/0000/0000",
                  row_out, key_state, key_pulse);
      else pass_cnt++;
      repeat (4) begin
         @(posedge clk);
         #1;
         total_cnt++;
         if (row_out !== 4'b1110 || key_state !== 16'h0000 || key_pulse !== 16'h0000)
            $display("FAIL mid_held_reset row_out=%b state=%h pulse=%h exp=1110/0000/0000",
                     row_out, key_state, key_pulse);
         else pass_cnt++;
      end
      @(negedge clk);
      rst = 1'b0;
      e = 0;
      while (e < 70) begin
         step();
         if (key_pulse !== 16'h0000) begin
            pulses++;
            pulse_edge = e;
         end
         if (e == 49) begin
            total_cnt++;
            if (key_state !== 16'h0000) $display("FAIL mid_state_before got=%h exp=%h", key_state, 16'h0000);
            else pass_cnt++;
         end
         if (e == 51) begin
            total_cnt++;
            if (key_pulse !== 16'h0200) $display("FAIL mid_pulse_value got=%h exp=%h", key_pulse, 16'h0200);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (pulses != 1 || pulse_edge != 51)
         $display("FAIL mid_pulse_timing count=%0d edge=%0d exp=1 at 51", pulses, pulse_edge);
      else pass_cnt++;
      $display("test_reset_mid: key 9 reset mid-debounce, pulse at edge %0d", pulse_edge);
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      e         = 0;
      pressed   = 16'h0000;
      rst       = 1'b1;
      test_reset();
      test_idle();
      test_press();
      test_release();
      test_bounce();
      test_two_keys();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
